// File: rtl/str_score_line_fetcher.sv
// str_score_line_fetcher
// Walks the SCORE glyph ROM during horizontal blanking. For each of the
// num_glyphs_p glyphs it fetches the row that belongs to the next scanline
// into a line buffer. It then serves one registered pixel per clock from
// the raster x coordinate.
// Optional build macro: STR_SCORE_SCALE2_EN enables 2x pixel doubling in
// both x and y, so the box becomes twice as wide and twice as tall.
module str_score_line_fetcher #(
  parameter int width_p       = 32,
  parameter int depth_p       = 512,
  parameter int num_glyphs_p  = 8,
  parameter int coord_width_p = 11,
  parameter int x_origin_p    = 200,
  parameter int y_origin_p    = 100
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic                       line_start_i,
  input  logic [coord_width_p-1:0]   y_i,
  input  logic [coord_width_p-1:0]   x_i,
  output logic [$clog2(depth_p)-1:0] rom_addr_o,
  input  logic [width_p-1:0]         rom_data_i,
  output logic                       busy_o,
  output logic                       line_valid_o,
  output logic                       pixel_o
);

  localparam int rows_lp    = depth_p / num_glyphs_p;
  localparam int addr_w_lp  = $clog2(depth_p);
  localparam int row_w_lp   = $clog2(rows_lp);
  localparam int glyph_w_lp = $clog2(num_glyphs_p);
  localparam int bit_w_lp   = $clog2(width_p);
  // One extra bit so that a coordinate left of / above the origin wraps to
  // a large unsigned value and fails the box compare.
  localparam int cw_lp      = coord_width_p + 1;

`ifdef STR_SCORE_SCALE2_EN
  localparam int scale_sh_lp = 1;
`else
  localparam int scale_sh_lp = 0;
`endif

  localparam logic [cw_lp-1:0]      x_org_lp      = cw_lp'(x_origin_p);
  localparam logic [cw_lp-1:0]      y_org_lp      = cw_lp'(y_origin_p);
  localparam logic [cw_lp-1:0]      box_h_lp      = cw_lp'(rows_lp << scale_sh_lp);
  localparam logic [cw_lp-1:0]      box_w_lp      = cw_lp'((num_glyphs_p * width_p) << scale_sh_lp);
  localparam logic [cw_lp-1:0]      width_c_lp    = cw_lp'(width_p);
  localparam logic [glyph_w_lp-1:0] last_glyph_lp = glyph_w_lp'(num_glyphs_p - 1);
  localparam logic [glyph_w_lp-1:0] one_glyph_lp  = glyph_w_lp'(1);
  localparam logic [addr_w_lp-1:0]  rows_addr_lp  = addr_w_lp'(rows_lp);
  localparam logic [bit_w_lp-1:0]   msb_idx_lp    = bit_w_lp'(width_p - 1);

  typedef enum logic {IDLE_S = 1'b0, FETCH_S = 1'b1} state_e;

  state_e                  state_q, state_d;
  logic [glyph_w_lp-1:0]   g_q, g_d;
  logic [row_w_lp-1:0]     row_q, row_d;
  logic [addr_w_lp-1:0]    rom_addr_q, rom_addr_d;
  logic                    busy_q, busy_d;
  logic                    line_valid_q, line_valid_d;
  logic                    pixel_q, pixel_d;
  logic [width_p-1:0]      line_buf_q [num_glyphs_p];

  logic [cw_lp-1:0]        dy_s, dx_s, col_s;
  logic                    y_in_box_s, x_in_box_s;
  logic [row_w_lp-1:0]     row_new_s;
  logic [glyph_w_lp-1:0]   glyph_idx_s;
  logic [bit_w_lp-1:0]     bit_idx_s;

  // Raster-to-box mapping; the shift folds in the optional pixel doubling.
  assign dy_s        = {1'b0, y_i} - y_org_lp;
  assign y_in_box_s  = (dy_s < box_h_lp);
  assign row_new_s   = row_w_lp'(dy_s >> scale_sh_lp);
  assign dx_s        = {1'b0, x_i} - x_org_lp;
  assign x_in_box_s  = (dx_s < box_w_lp);
  assign col_s       = dx_s >> scale_sh_lp;
  assign glyph_idx_s = glyph_w_lp'(col_s / width_c_lp);
  assign bit_idx_s   = bit_w_lp'(col_s % width_c_lp);

  // State register: sequencer state, glyph counter and latched row.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= IDLE_S;
      g_q     <= '0;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      row_q   <= row_d;
    end
  end

  // Next state: a line start (re)arms or cancels the fetch; otherwise
  // FETCH steps through the glyphs and returns to IDLE after the last one.
  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    row_d   = row_q;
    if (line_start_i) begin
      g_d = '0;
      if (y_in_box_s) begin
        state_d = FETCH_S;
        row_d   = row_new_s;
      end else begin
        state_d = IDLE_S;
      end
    end else begin
      case (state_q)
        FETCH_S: begin
          if (g_q == last_glyph_lp) begin
            state_d = IDLE_S;
            g_d     = '0;
          end else begin
            g_d = g_q + one_glyph_lp;
          end
        end
        IDLE_S:  state_d = IDLE_S;
        default: state_d = IDLE_S;
      endcase
    end
  end

  // Output decode: ROM address and busy follow the upcoming state so they
  // leave the flops aligned with the fetch cycle they describe.
  always_comb begin
    rom_addr_d   = '0;
    busy_d       = 1'b0;
    line_valid_d = line_valid_q;
    pixel_d      = 1'b0;
    case (state_d)
      FETCH_S: begin
        rom_addr_d = addr_w_lp'(g_d) * rows_addr_lp + addr_w_lp'(row_d);
        busy_d     = 1'b1;
      end
      IDLE_S:  busy_d = 1'b0;
      default: busy_d = 1'b0;
    endcase
    if (line_start_i) begin
      line_valid_d = 1'b0;
    end else if ((state_q == FETCH_S) && (g_q == last_glyph_lp)) begin
      line_valid_d = 1'b1;
    end else begin
      line_valid_d = line_valid_q;
    end
    // MSB of each stored row is the leftmost pixel of that glyph.
    if (line_valid_q && x_in_box_s) begin
      pixel_d = line_buf_q[glyph_idx_s][msb_idx_lp - bit_idx_s];
    end else begin
      pixel_d = 1'b0;
    end
  end

  // Output registers; reset clears them immediately so the compositor sees
  // a blank line as soon as reset asserts.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rom_addr_q   <= '0;
      busy_q       <= 1'b0;
      line_valid_q <= 1'b0;
      pixel_q      <= 1'b0;
    end else begin
      rom_addr_q   <= rom_addr_d;
      busy_q       <= busy_d;
      line_valid_q <= line_valid_d;
      pixel_q      <= pixel_d;
    end
  end

  // Line buffer capture; contents need no reset because line_valid masks them.
  always_ff @(posedge clk_i) begin
    if (state_q == FETCH_S) begin
      line_buf_q[g_q] <= rom_data_i;
    end
  end

  assign rom_addr_o   = rom_addr_q;
  assign busy_o       = busy_q;
  assign line_valid_o = line_valid_q;
  assign pixel_o      = pixel_q;

endmodule
